// File: rtl/finalproject_soc_pio_pkg.sv
// Shared register map and edge-type encodings for the SoC parallel I/O port.
package finalproject_soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/finalproject_soc_pio_sync.sv
// Input synchroniser chain, one-cycle-delayed copy and per-bit edge pulse.
module finalproject_soc_pio_sync
  import finalproject_soc_pio_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 2,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [DEPTH-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]            prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], din};
      prev  <= chain[DEPTH-1];
    end
  end

  assign sync_out = chain[DEPTH-1];

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_pulse = ~sync_out & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_pulse = sync_out ^ prev;
    end else begin : g_rise
      assign edge_pulse = sync_out & ~prev;
    end
  endgenerate

endmodule

// File: rtl/finalproject_soc_pio_edge.sv
// Avalon-MM PIO with direction, synchronised input, edge capture (W1C) and masked irq.
// Optional OUTSET/OUTCLR registers enabled by FINALPROJECT_SOC_PIO_BITSET_EN.
module finalproject_soc_pio_edge
  import finalproject_soc_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  unused_wdata;
  logic [DATA_WIDTH-1:0] sync_in, edge_pulse;
  logic [DATA_WIDTH-1:0] out_q, out_nxt, dir_q, mask_q, cap_q, cap_clr, rd_sel;
  logic                  irq_q;
  logic [31:0]           rd_q;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  finalproject_soc_pio_sync #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (SYNC_STAGES),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (in_port),
    .sync_out   (sync_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    out_nxt = out_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   out_nxt = wdata;
`ifdef FINALPROJECT_SOC_PIO_BITSET_EN
        ADDR_OUTSET: out_nxt = out_q | wdata;
        ADDR_OUTCLR: out_nxt = out_q & ~wdata;
`endif
        default:     out_nxt = out_q;
      endcase
    end
  end

  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  // Bit-set registers and reserved addresses all fall through to zero.
  always_comb begin
    rd_sel = '0;
    case (address)
      ADDR_DATA:    rd_sel = sync_in;
      ADDR_DIR:     rd_sel = dir_q;
      ADDR_IRQMASK: rd_sel = mask_q;
      ADDR_EDGECAP: rd_sel = cap_q;
      default:      rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VALUE;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      out_q <= out_nxt;
      if (wr && address == ADDR_DIR)     dir_q  <= wdata;
      if (wr && address == ADDR_IRQMASK) mask_q <= wdata;
      // A fresh edge outranks a same-cycle clear so no event is lost.
      cap_q <= (cap_q & ~cap_clr) | edge_pulse;
      irq_q <= |(cap_q & mask_q);
      rd_q  <= 32'(rd_sel);
    end
  end

  assign out_port = out_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;
  assign readdata = rd_q;

endmodule
